// File: rtl/pcs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcs_pkg
// Purpose  : Shared PCS definitions. Holds the K-code control characters used
//            by both the transmit framer and the receive demux, plus the
//            framer state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pcs_pkg;

  // Control characters (sent with valid_out = 0)
  localparam logic [7:0] c_k_stp = 8'hFB;
  localparam logic [7:0] c_k_sdp = 8'h5C;
  localparam logic [7:0] c_k_end = 8'hFD;
  localparam logic [7:0] c_k_edb = 8'hFE;
  localparam logic [7:0] c_k_skp = 8'h1C;
  localparam logic [7:0] c_k_idl = 8'h7C;
  localparam logic [7:0] c_k_fts = 8'h3C;
  localparam logic [7:0] c_k_com = 8'hBC;

  // Framer state encoding
  typedef logic [2:0] framer_state_t;

  localparam framer_state_t c_st_idle   = 3'd0;
  localparam framer_state_t c_st_start  = 3'd1;
  localparam framer_state_t c_st_data   = 3'd2;
  localparam framer_state_t c_st_end    = 3'd3;
  localparam framer_state_t c_st_drop   = 3'd4;
  localparam framer_state_t c_st_os_com = 3'd5;
  localparam framer_state_t c_st_os_skp = 3'd6;

endpackage
`default_nettype wire

// File: rtl/pcs_tx_framer_skp_timer.sv
`default_nettype none
// ============================================================================
// Module   : skp_timer
// Purpose  : Interval timer requesting a SKP ordered set every SKP_INTERVAL
//            cycles. Counts 0..SKP_INTERVAL-1, raises pending at terminal
//            count and then holds until restarted by COM emission.
// Ports    : clk      - clock
//            reset_L  - asynchronous active-low reset
//            restart  - COM being emitted this cycle: clear pending, count 0
//            pending  - ordered set requested
// Revision : 1.0 - initial release
// ============================================================================
module skp_timer #(
  parameter int SKP_INTERVAL = 64
) (
  input  logic clk,
  input  logic reset_L,
  input  logic restart,
  output logic pending
);

  localparam int CW = $clog2(SKP_INTERVAL);
  localparam logic [CW-1:0] c_tc = CW'(SKP_INTERVAL - 1);

  logic [CW-1:0] r_cnt;
  logic          r_pending;

  // Restart has priority, so a terminal count coinciding with COM emission
  // is discarded.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else if (restart) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else if (r_cnt == c_tc) begin
      r_pending <= 1'b1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/pcs_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : pcs_tx_framer
// Purpose  : Transmit byte framer. Wraps packets in STP..END, fills gaps with
//            IDL, inserts COM+SKP ordered sets at packet boundaries and aborts
//            underrunning packets with EDB.
// Ports    : clk        - clock
//            reset_L    - asynchronous active-low reset
//            pkt_valid  - upstream byte available
//            pkt_data   - packet byte
//            pkt_last   - byte is the last of its packet
//            pkt_ready  - byte accepted when pkt_valid is high (state only)
//            data_out   - transmitted symbol (registered)
//            valid_out  - 1 = data byte, 0 = control character (registered)
// Revision : 1.0 - initial release
// ============================================================================
module pcs_tx_framer
  import pcs_pkg::*;
#(
  parameter int SKP_INTERVAL = 64,
  parameter int SKP_COUNT    = 3
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       pkt_valid,
  input  logic [7:0] pkt_data,
  input  logic       pkt_last,
  output logic       pkt_ready,
  output logic [7:0] data_out,
  output logic       valid_out
);

  localparam logic [1:0] c_skp_last = 2'(SKP_COUNT - 1);

  framer_state_t r_state;
  framer_state_t w_next_state;
  framer_state_t w_boundary_next;
  logic [1:0]    r_skp_idx;
  logic [7:0]    w_sym;
  logic          w_sym_valid;
  logic          w_skp_pending;
  logic          w_restart;

  // COM is emitted in exactly one cycle per ordered set; that cycle restarts
  // the interval.
  assign w_restart = (r_state == c_st_os_com);

  skp_timer #(
    .SKP_INTERVAL (SKP_INTERVAL)
  ) u_skp_timer (
    .clk     (clk),
    .reset_L (reset_L),
    .restart (w_restart),
    .pending (w_skp_pending)
  );

  assign pkt_ready = (r_state == c_st_data) || (r_state == c_st_drop);

  // Shared boundary decision: ordered set beats new packet beats idle.
  always_comb begin
    if (w_skp_pending) begin
      w_boundary_next = c_st_os_com;
    end else if (pkt_valid) begin
      w_boundary_next = c_st_start;
    end else begin
      w_boundary_next = c_st_idle;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_sym        = c_k_idl;
    w_sym_valid  = 1'b0;
    case (r_state)
      c_st_idle: begin
        w_next_state = w_boundary_next;
      end
      c_st_start: begin
        w_sym        = c_k_stp;
        w_next_state = c_st_data;
      end
      c_st_data: begin
        if (pkt_valid) begin
          w_sym       = pkt_data;
          w_sym_valid = 1'b1;
          if (pkt_last) begin
            w_next_state = c_st_end;
          end
        end else begin
          w_sym        = c_k_edb;
          w_next_state = c_st_drop;
        end
      end
      c_st_drop: begin
        // Remainder of an aborted packet is swallowed behind IDL.
        if (pkt_valid && pkt_last) begin
          w_next_state = c_st_idle;
        end
      end
      c_st_end: begin
        w_sym        = c_k_end;
        w_next_state = w_boundary_next;
      end
      c_st_os_com: begin
        w_sym        = c_k_com;
        w_next_state = c_st_os_skp;
      end
      c_st_os_skp: begin
        w_sym = c_k_skp;
        if (r_skp_idx == c_skp_last) begin
          w_next_state = w_boundary_next;
        end
      end
      default: begin
        w_next_state = c_st_idle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state   <= c_st_idle;
      r_skp_idx <= 2'd0;
      data_out  <= c_k_idl;
      valid_out <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_skp_idx <= (r_state == c_st_os_skp) ? r_skp_idx + 2'd1 : 2'd0;
      data_out  <= w_sym;
      valid_out <= w_sym_valid;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pcs_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcs_tx_framer
// Purpose  : Directed self-checking bench for pcs_tx_framer (SKP_INTERVAL=16,
//            SKP_COUNT=3). Upstream bytes come from a queue; a byte leaves
//            the queue only on a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcs_tx_framer;
  import pcs_pkg::*;

  localparam int SKP_INTERVAL = 16;
  localparam int SKP_COUNT    = 3;

  logic       clk       = 1'b0;
  logic       reset_L   = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [7:0] pkt_data  = 8'h00;
  logic       pkt_last  = 1'b0;
  logic       pkt_ready;
  logic [7:0] data_out;
  logic       valid_out;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q_data[$];
  logic       q_last[$];
  logic       src_en = 1'b0;

  always #5 clk = ~clk;

  pcs_tx_framer #(
    .SKP_INTERVAL (SKP_INTERVAL),
    .SKP_COUNT    (SKP_COUNT)
  ) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .pkt_valid (pkt_valid),
    .pkt_data  (pkt_data),
    .pkt_last  (pkt_last),
    .pkt_ready (pkt_ready),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  task automatic check_sym(input string tag, input logic [7:0] exp_d, input logic exp_v);
    n_vec++;
    assert ({data_out, valid_out} === {exp_d, exp_v}) else begin
      n_err++;
      $error("FAIL %s: observed %h/%b expected %h/%b", tag, data_out, valid_out, exp_d, exp_v);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    q_data.push_back(d);
    q_last.push_back(l);
  endtask

  // Called at a negedge: present the queue head, step one clock, pop on
  // handshake, return at the following negedge with outputs settled.
  task automatic tick();
    logic hs;
    pkt_valid = src_en && (q_data.size() != 0);
    pkt_data  = pkt_valid ? q_data[0] : 8'h00;
    pkt_last  = pkt_valid ? q_last[0] : 1'b0;
    #1;
    hs = pkt_valid && pkt_ready;
    @(posedge clk);
    if (hs) begin
      void'(q_data.pop_front());
      void'(q_last.pop_front());
    end
    @(negedge clk);
  endtask

  // Step until a given control symbol shows, within a cycle budget.
  task automatic wait_sym(input string tag, input logic [7:0] sym, input int bound);
    int k = 0;
    while (!(data_out === sym && valid_out === 1'b0) && k < bound) begin
      tick();
      k++;
    end
    check_sym(tag, sym, 1'b0);
  endtask

  // Align to the end of an ordered set so the next one is ~14 cycles away.
  task automatic sync_os(input string tag);
    wait_sym({tag, "_com"}, c_k_com, 40);
    for (int i = 0; i < SKP_COUNT; i++) begin
      tick();
      check_sym({tag, "_skp"}, c_k_skp, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  gap;
    int  clean;

    // ---------------- reset ----------------
    #3 reset_L = 1'b0;
    #1;
    check_sym("rst_out", c_k_idl, 1'b0);
    check_int("rst_ready", int'(pkt_ready), 0);
    @(negedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    tick();
    check_sym("idle_out", c_k_idl, 1'b0);
    check_int("idle_ready", int'(pkt_ready), 0);

    // ---------------- single 3-byte packet ----------------
    sync_os("s1");
    src_en = 1'b1;
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b1);
    wait_sym("sp_stp", c_k_stp, 4);
    tick(); check_sym("sp_d0",  8'h11, 1'b1);
    tick(); check_sym("sp_d1",  8'h22, 1'b1);
    tick(); check_sym("sp_d2",  8'h33, 1'b1);
    tick(); check_sym("sp_end", c_k_end, 1'b0);
    tick(); check_sym("sp_idl", c_k_idl, 1'b0);

    // ---------------- back-to-back packets ----------------
    sync_os("s2");
    push(8'hA1, 1'b0); push(8'hA2, 1'b1); push(8'hB1, 1'b1);
    wait_sym("bb_stp0", c_k_stp, 4);
    tick(); check_sym("bb_a1",   8'hA1, 1'b1);
    tick(); check_sym("bb_a2",   8'hA2, 1'b1);
    tick(); check_sym("bb_end0", c_k_end, 1'b0);
    tick(); check_sym("bb_stp1", c_k_stp, 1'b0);
    tick(); check_sym("bb_b1",   8'hB1, 1'b1);
    tick(); check_sym("bb_end1", c_k_end, 1'b0);
    tick(); check_sym("bb_idl",  c_k_idl, 1'b0);

    // ---------------- underrun ----------------
    sync_os("s3");
    push(8'hC1, 1'b0); push(8'hC2, 1'b0); push(8'hC3, 1'b0);
    push(8'hC4, 1'b0); push(8'hC5, 1'b1);
    wait_sym("ur_stp", c_k_stp, 4);
    tick(); check_sym("ur_c1", 8'hC1, 1'b1);
    tick(); check_sym("ur_c2", 8'hC2, 1'b1);
    src_en = 1'b0;
    tick(); check_sym("ur_edb", c_k_edb, 1'b0);
    src_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check_sym("ur_drop_idl", c_k_idl, 1'b0);
    end
    check_int("ur_drained", q_data.size(), 0);
    push(8'hD1, 1'b1);
    wait_sym("ur_next_stp", c_k_stp, 4);
    tick(); check_sym("ur_next_d1",  8'hD1, 1'b1);
    tick(); check_sym("ur_next_end", c_k_end, 1'b0);

    // ---------------- K-code value as data ----------------
    sync_os("s4");
    push(8'hBC, 1'b1);
    wait_sym("kd_stp", c_k_stp, 4);
    tick(); check_sym("kd_data", 8'hBC, 1'b1);
    tick(); check_sym("kd_end",  c_k_end, 1'b0);
    tick(); check_sym("kd_idl",  c_k_idl, 1'b0);

    // ---------------- SKP pending across a 20-byte packet ----------------
    sync_os("s5");
    for (int i = 0; i < 20; i++) push(8'h40 + 8'(i), (i == 19));
    wait_sym("lp_stp", c_k_stp, 4);
    for (int i = 0; i < 20; i++) begin
      tick(); check_sym("lp_data", 8'h40 + 8'(i), 1'b1);
    end
    tick(); check_sym("lp_end", c_k_end, 1'b0);
    tick(); check_sym("lp_com", c_k_com, 1'b0);
    for (int i = 0; i < SKP_COUNT; i++) begin
      tick(); check_sym("lp_skp", c_k_skp, 1'b0);
    end

    // Idle recurrence: COM-to-COM spacing, only IDL between sets.
    gap   = SKP_COUNT;
    clean = 1;
    do begin
      tick();
      gap++;
      if (!(data_out === c_k_com) && !(data_out === c_k_idl && valid_out === 1'b0)) clean = 0;
    end while (!(data_out === c_k_com) && gap < 40);
    check_sym("os_period_com", c_k_com, 1'b0);
    check_int("os_period_min", int'(gap >= SKP_INTERVAL), 1);
    check_int("os_period_max", int'(gap <= SKP_INTERVAL + 2), 1);
    check_int("os_gap_idl", clean, 1);
    for (int i = 0; i < SKP_COUNT; i++) begin
      tick(); check_sym("os_period_skp", c_k_skp, 1'b0);
    end

    // ---------------- reset mid-packet ----------------
    push(8'hE1, 1'b0); push(8'hE2, 1'b0); push(8'hE3, 1'b0); push(8'hE4, 1'b1);
    wait_sym("rm_stp", c_k_stp, 4);
    tick(); check_sym("rm_e1", 8'hE1, 1'b1);
    #2 reset_L = 1'b0;
    #1;
    check_sym("rm_rst_out", c_k_idl, 1'b0);
    check_int("rm_rst_ready", int'(pkt_ready), 0);
    src_en    = 1'b0;
    pkt_valid = 1'b0;
    pkt_last  = 1'b0;
    q_data.delete();
    q_last.delete();
    @(negedge clk);
    reset_L = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); check_sym("rm_after_idl", c_k_idl, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
